// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the single address/data port of the register file between two requesters.
// Each command runs IDLE -> ACCESS -> RESP, so a transaction always costs three
// cycles and the winner sees a one-cycle ack (with err for a blocked write).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | sample requests, pick winner round-robin, load port registers
// ST_ACCESS | drive rf_* for the latched command, capture read data
// ST_RESP   | pulse winner's ack/err, hand priority to the other requester
module regfile_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter logic [(2**ADDR_WIDTH)-1:0] WR_PROTECT_MASK = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ack,
   output logic                  a_err,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ack,
   output logic                  b_err,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   output logic                  rf_we,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_ptr;
   logic                  r_id;
   logic                  r_we;
   logic                  r_prot;
   logic                  r_a_ack;
   logic                  r_a_err;
   logic                  r_b_ack;
   logic                  r_b_err;
   logic [DATA_WIDTH-1:0] r_a_rdata;
   logic [DATA_WIDTH-1:0] r_b_rdata;
   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic                  r_rf_we;
   logic [DATA_WIDTH-1:0] r_rf_wdata;
   logic                  r_busy;

   logic                  w_grant_b;
   logic                  w_sel_we;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic                  w_sel_prot;
   logic                  w_wr_ok;

   // B wins when it is the only requester, or both request and the pointer favours B.
   assign w_grant_b   = b_req & (~a_req | r_ptr);
   assign w_sel_we    = w_grant_b ? b_we    : a_we;
   assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
   assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
   assign w_sel_prot  = WR_PROTECT_MASK[w_sel_addr];
   assign w_wr_ok     = w_sel_we & ~w_sel_prot;

   // Sequencer with all outputs registered; port values are loaded on the IDLE->ACCESS
   // edge so that rf_* are valid for exactly the ACCESS cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= 1'b0;
         r_id       <= 1'b0;
         r_we       <= 1'b0;
         r_prot     <= 1'b0;
         r_a_ack    <= 1'b0;
         r_a_err    <= 1'b0;
         r_b_ack    <= 1'b0;
         r_b_err    <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
         r_rf_addr  <= '0;
         r_rf_we    <= 1'b0;
         r_rf_wdata <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (a_req | b_req) begin
                  r_id       <= w_grant_b;
                  r_we       <= w_sel_we;
                  r_prot     <= w_sel_we & w_sel_prot;
                  r_rf_addr  <= w_sel_addr;
                  r_rf_we    <= w_wr_ok;
                  r_rf_wdata <= w_wr_ok ? w_sel_wdata : '0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!r_we) begin
                  if (r_id) r_b_rdata <= rf_rdata;
                  else      r_a_rdata <= rf_rdata;
               end
               r_rf_addr  <= '0;
               r_rf_we    <= 1'b0;
               r_rf_wdata <= '0;
               r_a_ack    <= ~r_id;
               r_b_ack    <= r_id;
               r_a_err    <= ~r_id & r_prot;
               r_b_err    <= r_id & r_prot;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               r_a_ack <= 1'b0;
               r_a_err <= 1'b0;
               r_b_ack <= 1'b0;
               r_b_err <= 1'b0;
               r_ptr   <= ~r_id;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign a_ack    = r_a_ack;
   assign a_err    = r_a_err;
   assign a_rdata  = r_a_rdata;
   assign b_ack    = r_b_ack;
   assign b_err    = r_b_err;
   assign b_rdata  = r_b_rdata;
   assign rf_addr  = r_rf_addr;
   assign rf_we    = r_rf_we;
   assign rf_wdata = r_rf_wdata;
   assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: an 8 x 32 register file model drives rf_rdata,
// a transaction-phase model predicts every output each cycle, and directed
// scenarios pin latency, ordering, protection and reset behaviour with literals.
module tb_regfile_port_arbiter;

   localparam logic [7:0] MASK = 8'h01;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [2:0]  a_addr = '0;
   logic [31:0] a_wdata = '0;
   logic        b_req = 1'b0, b_we = 1'b0;
   logic [2:0]  b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic        a_ack, a_err, b_ack, b_err, rf_we, busy;
   logic [31:0] a_rdata, b_rdata, rf_wdata, rf_rdata;
   logic [2:0]  rf_addr;

   int checks = 0;
   int errors = 0;

   logic [31:0] rf_mem [8] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h0000_0100,
                               32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007};

   regfile_port_arbiter #(
      .DATA_WIDTH(32), .ADDR_WIDTH(3), .WR_PROTECT_MASK(MASK)
   ) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, write on the edge ending an rf_we cycle.
   assign rf_rdata = rf_mem[rf_addr];
   always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- transaction-phase model ----------------
   // m_k counts cycles since the grant edge: 0 = no transaction in flight,
   // 1 = the port cycle, 2 = the acknowledge cycle.
   int          m_k = 0;
   int          m_ptr = 0;
   int          m_win = 0;
   bit          m_we, m_prot, m_valid = 0;
   int          m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata [2];
   logic [31:0] m_mem [8] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h0000_0100,
                              32'h5555_0004, 32'h6666_0005, 32'h7777_0006, 32'h8888_0007};

   always @(posedge clk) begin
      if (reset) begin
         if (m_k == 1 && m_we && !m_prot) m_mem[m_addr] = m_wdata;
         m_k = 0; m_ptr = 0; m_rdata[0] = 0; m_rdata[1] = 0; m_valid = 1;
      end else if (m_k == 1) begin
         if (m_we) begin
            if (!m_prot) m_mem[m_addr] = m_wdata;
         end else begin
            m_rdata[m_win] = m_mem[m_addr];
         end
         m_k = 2;
      end else if (m_k == 2) begin
         m_ptr = 1 - m_win;
         m_k = 0;
      end else if (a_req || b_req) begin
         m_win   = (a_req && b_req) ? m_ptr : (a_req ? 0 : 1);
         m_we    = (m_win == 0) ? a_we : b_we;
         m_addr  = (m_win == 0) ? int'(a_addr) : int'(b_addr);
         m_wdata = (m_win == 0) ? a_wdata : b_wdata;
         m_prot  = m_we && MASK[m_addr];
         m_k = 1;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy",    {31'd0, busy},  {31'd0, (m_k != 0)});
         chk("rf_we",   {31'd0, rf_we}, {31'd0, (m_k == 1 && m_we && !m_prot)});
         chk("rf_addr", {29'd0, rf_addr}, (m_k == 1) ? m_addr : 0);
         if (m_k != 1) chk("rf_wdata_idle", rf_wdata, 32'h0);
         else if (m_we && !m_prot) chk("rf_wdata", rf_wdata, m_wdata);
         chk("a_ack", {31'd0, a_ack}, {31'd0, (m_k == 2 && m_win == 0)});
         chk("b_ack", {31'd0, b_ack}, {31'd0, (m_k == 2 && m_win == 1)});
         chk("a_err", {31'd0, a_err}, {31'd0, (m_k == 2 && m_win == 0 && m_prot)});
         chk("b_err", {31'd0, b_err}, {31'd0, (m_k == 2 && m_win == 1 && m_prot)});
         chk("a_rdata", a_rdata, m_rdata[0]);
         chk("b_rdata", b_rdata, m_rdata[1]);
      end
   end

   // ---------------- directed scenarios ----------------
   int log_who [8];
   int log_at  [8];
   int log_n;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the given requester's ack; returns at the negedge of the ack cycle.
   task automatic wait_ack(input int who, output int n, output int we_cnt,
                           output logic [2:0] we_addr, output logic err);
      n = -1; we_cnt = 0; we_addr = '0; err = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rf_we) begin
            we_cnt++;
            we_addr = rf_addr;
         end
         if ((who == 0) ? a_ack : b_ack) begin
            n = i;
            err = (who == 0) ? a_err : b_err;
            break;
         end
      end
      if (n < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack for requester %0d, expected one within 12 cycles", who);
      end
   endtask

   // Records up to 'want' acks (who and cycle offset from the first sampled cycle).
   task automatic collect(input int want, input int budget);
      log_n = 0;
      for (int c = 0; c < budget && log_n < want; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            if (log_n < 8) begin
               log_who[log_n] = a_ack ? 0 : 1;
               log_at[log_n]  = c;
            end
            log_n++;
         end
      end
   endtask

   initial begin
      int          n, wc;
      logic [2:0]  wa;
      logic        e;

      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy",    {31'd0, busy},  32'd0);
      chk("rst_a_rdata", a_rdata,        32'd0);
      chk("rst_b_rdata", b_rdata,        32'd0);
      chk("rst_rf_we",   {31'd0, rf_we}, 32'd0);
      tick();

      // 1) A reads reg3
      a_we = 1'b0; a_addr = 3'd3; a_req = 1'b1;
      wait_ack(0, n, wc, wa, e);
      chk("t1_latency", n, 2);
      chk("t1_rdata", a_rdata, 32'h0000_0100);
      chk("t1_b_ack", {31'd0, b_ack}, 32'd0);
      tick();
      a_req = 1'b0;

      // 2) both requesters held after reset: A,B,A,B every 3 cycles
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_we = 1'b0; a_addr = 3'd3;
      b_we = 1'b1; b_addr = 3'd6; b_wdata = 32'h6060_6060;
      a_req = 1'b1; b_req = 1'b1;
      collect(4, 30);
      chk("t2_count", log_n, 4);
      for (int i = 0; i < 4 && i < log_n; i++) begin
         chk("t2_order", log_who[i], i % 2);
         chk("t2_spacing", log_at[i], 2 + 3 * i);
      end
      tick();
      a_req = 1'b0; b_req = 1'b0;
      chk("t2_reg6", rf_mem[6], 32'h6060_6060);

      // 3) B writes protected reg0
      b_we = 1'b1; b_addr = 3'd0; b_wdata = 32'hDEAD_BEEF; b_req = 1'b1;
      wait_ack(1, n, wc, wa, e);
      chk("t3_latency", n, 2);
      chk("t3_no_we", wc, 0);
      chk("t3_err", {31'd0, e}, 32'd1);
      chk("t3_b_rdata", b_rdata, 32'd0);
      tick();
      b_req = 1'b0;
      chk("t3_reg0", rf_mem[0], 32'h1111_0000);

      // 4) B writes reg7 then reads it back with req held across the ack edge
      b_we = 1'b1; b_addr = 3'd7; b_wdata = 32'hDEAD_BEEF; b_req = 1'b1;
      wait_ack(1, n, wc, wa, e);
      chk("t4w_we_pulses", wc, 1);
      chk("t4w_we_addr", {29'd0, wa}, 32'd7);
      chk("t4w_err", {31'd0, e}, 32'd0);
      tick();
      b_we = 1'b0;
      wait_ack(1, n, wc, wa, e);
      chk("t4r_latency", n, 2);
      chk("t4r_rdata", b_rdata, 32'hDEAD_BEEF);
      chk("t4r_err", {31'd0, e}, 32'd0);
      tick();
      b_req = 1'b0;

      // 5) reset during the ack cycle of an A read
      a_we = 1'b0; a_addr = 3'd5; a_req = 1'b1;
      wait_ack(0, n, wc, wa, e);
      chk("t5_rdata_pre", a_rdata, 32'h6666_0005);
      #1;
      reset = 1'b1; a_req = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
      chk("t5_a_rdata_cleared", a_rdata, 32'd0);
      tick();
      a_we = 1'b0; a_addr = 3'd3; b_we = 1'b0; b_addr = 3'd4;
      a_req = 1'b1; b_req = 1'b1;
      collect(2, 12);
      chk("t5_count", log_n, 2);
      if (log_n > 0) chk("t5_first", log_who[0], 0);
      if (log_n > 1) chk("t5_second", log_who[1], 1);
      tick();
      a_req = 1'b0; b_req = 1'b0;
      chk("t5_b_rdata", b_rdata, 32'h5555_0004);

      // 6) B alone, four back-to-back reads
      b_we = 1'b0; b_addr = 3'd3; b_req = 1'b1;
      collect(4, 20);
      chk("t6_count", log_n, 4);
      for (int i = 0; i < 4 && i < log_n; i++) begin
         chk("t6_who", log_who[i], 1);
         chk("t6_spacing", log_at[i], 2 + 3 * i);
      end
      tick();
      b_req = 1'b0;

      // 7) reset during the port cycle of a write: write still lands, no ack
      b_we = 1'b1; b_addr = 3'd4; b_wdata = 32'h4444_AAAA; b_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t7_we_access", {31'd0, rf_we}, 32'd1);
      chk("t7_addr_access", {29'd0, rf_addr}, 32'd4);
      #1;
      reset = 1'b1; b_req = 1'b0;
      tick();
      reset = 1'b0;
      collect(1, 6);
      chk("t7_no_ack", log_n, 0);
      chk("t7_reg4", rf_mem[4], 32'h4444_AAAA);

      for (int i = 0; i < 8; i++) chk("final_mem", rf_mem[i], m_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
